// File: rtl/bcd_scan_display.sv
// bcd_scan_display: converts a binary value to 4 BCD digits with a sequential
// shift-add-3 engine and scans the digits onto a 4-digit common-anode
// 7-segment display (active-low anodes and segments).
// Optional feature: define LEADING_ZERO_BLANK_EN to blank the leading zero digits
// above the most significant nonzero digit. Digit 0 is never blanked.
module bcd_scan_display #(
   parameter int BIN_W       = 8,
   parameter int REFRESH_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BIN_W-1:0] bin_in,
   input  logic             load,
   output logic             busy,
   output logic [15:0]      bcd_out,
   output logic             bcd_valid,
   output logic [3:0]       an,
   output logic [6:0]       seg,
   output logic             dp
);

   localparam int CW = $clog2(BIN_W + 1);
   localparam int RW = $clog2(REFRESH_DIV);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t           state;
   logic [BIN_W-1:0] shreg;
   logic [15:0]      scratch;
   logic [15:0]      adj;
   logic [CW-1:0]    iter;
   logic [RW-1:0]    refresh;
   logic [1:0]       idx;
   logic [3:0]       digit;
   logic             blank;
   logic [6:0]       seg_next;

   // Decimal point is never used by this display.
   assign dp = 1'b1;

   // Add-3 correction of every BCD nibble that would overflow on the next shift.
   always_comb begin
      adj = scratch;
      for (int i = 0; i < 4; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   // Conversion sequencer: accept a value, run BIN_W shift steps, publish the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         bcd_out   <= 16'd0;
         bcd_valid <= 1'b0;
         shreg     <= '0;
         scratch   <= 16'd0;
         iter      <= '0;
      end else begin
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  shreg   <= bin_in;
                  scratch <= 16'd0;
                  iter    <= CW'(BIN_W);
                  busy    <= 1'b1;
                  state   <= CONV;
               end
            end
            CONV: begin
               scratch <= (adj << 1) | {15'd0, shreg[BIN_W-1]};
               shreg   <= shreg << 1;
               iter    <= iter - 1'b1;
               if (iter == CW'(1))
                  state <= DONE;
            end
            DONE: begin
               bcd_out   <= scratch;
               bcd_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Refresh timer: each digit stays lit for REFRESH_DIV cycles, then the scan moves on.
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh <= '0;
         idx     <= 2'd0;
      end else if (refresh == REFRESH_LAST) begin
         refresh <= '0;
         idx     <= idx + 2'd1;
      end else begin
         refresh <= refresh + 1'b1;
      end
   end

   // Select the digit currently being scanned and decide whether it is a blanked leading zero.
   always_comb begin
      digit = bcd_out[{idx, 2'b00} +: 4];
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      case (idx)
         2'd1:    blank = (bcd_out[15:4] == 12'd0);
         2'd2:    blank = (bcd_out[15:8] == 8'd0);
         2'd3:    blank = (bcd_out[15:12] == 4'd0);
         default: blank = 1'b0;
      endcase
`endif
   end

   // Seven-segment decode, active-low {g,f,e,d,c,b,a}; anything that is not 0-9 stays dark.
   always_comb begin
      seg_next = 7'b1111111;
      if (!blank) begin
         case (digit)
            4'd0:    seg_next = 7'b1000000;
            4'd1:    seg_next = 7'b1111001;
            4'd2:    seg_next = 7'b0100100;
            4'd3:    seg_next = 7'b0110000;
            4'd4:    seg_next = 7'b0011001;
            4'd5:    seg_next = 7'b0010010;
            4'd6:    seg_next = 7'b0000010;
            4'd7:    seg_next = 7'b1111000;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0010000;
            default: seg_next = 7'b1111111;
         endcase
      end
   end

   // Register the anode enable and segment pattern so the display pins are glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= 4'b1111;
         seg <= 7'b1111111;
      end else begin
         an  <= ~(4'b0001 << idx);
         seg <= seg_next;
      end
   end

endmodule
